fetch_queue: RTL
================

# fetch_queue

Instruction prefetch buffer between the synchronous instruction memory and the cpu core. It generates sequential fetch addresses, captures the one-cycle-latency instruction responses into a small circular queue tagged with their PC, and presents them to the core with a valid/ready handshake. On a branch or jump redirect it flushes all queued and in-flight instructions and restarts fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  16  fetch address to instruction memory; equals fetch_pc register.
- fetch_req  out  1  a fetch is issued this cycle; forced 0 while reset is asserted.
- imem_data  in  16  instruction word, valid the cycle after the matching fetch_req.
- redirect_valid  in  1  core requests a flush and restart.
- redirect_pc  in  16  restart address, sampled when redirect_valid=1.
- instr_valid  out  1  head entry is available.
- instr  out  16  head instruction.
- instr_pc  out  16  PC of head instruction.
- deq_ready  in  1  core consumes head when instr_valid=1.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: fetch_pc (16b), inflight (1b), queue storage, rd_ptr/wr_ptr with wrap bit, count.
- Issue: fetch_req = !redirect_valid && (count + inflight < DEPTH). Issuing sets inflight and fetch_pc <= fetch_pc + 1 (word address, wraps 16'hFFFF -> 16'h0000). No credit is taken for a same-cycle dequeue.
- Capture: if inflight=1 in a cycle, imem_data and the PC issued the prior cycle are written at wr_ptr; inflight clears unless a new fetch issues.
- Dequeue: instr_valid = (count != 0) && !redirect_valid; instr_valid && deq_ready advances rd_ptr.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Enqueue into a full queue is unreachable by construction.
- Redirect (highest priority): count<=0, rd_ptr=wr_ptr<=0, inflight<=0 (the pending response is discarded), fetch_pc<=redirect_pc, no fetch issued, dequeue in the same cycle ignored.
- Reset values: fetch_pc=RESET_PC, imem_addr=RESET_PC, inflight=0, count=0, instr_valid=0, instr=16'h0000, instr_pc=16'h0000 (outputs driven from cleared storage), fetch_req=0.
- Reset asserted mid-operation clears all state immediately. The in-flight response is never captured.

## Timing
- First cycle after reset release: fetch_req=1, imem_addr=RESET_PC.
- Fetch issued in cycle N produces an entry written at the end of N+1. instr_valid=1 in N+2 (non-bypass).
- Redirect in cycle R: fetch of redirect_pc in R+1, instr_valid in R+3 (R+2 with bypass).
- Steady-state throughput is one instruction per cycle when DEPTH>=3 and deq_ready is held high.

## Configuration
- FETCHQ_BYPASS_EN defined: when count=0 and a response is captured, instr/instr_pc/instr_valid are driven combinationally from imem_data in N+1. If deq_ready=1, the word is consumed and not written into the queue; otherwise it is written normally.
- Undefined: outputs come only from queue storage, with a 2-cycle fetch-to-valid latency.

## Structure
- Package fetchq_pkg: typedef struct packed {logic [15:0] instr; logic [15:0] pc;} fq_entry_t; localparam WORD_W=16.
- Sub-module fetchq_fifo: circular buffer of fq_entry_t with push, pop, flush, count, and wrap-bit full/empty. fetch_queue owns fetch_pc, inflight, redirect, and bypass logic.

## Test plan
- Reset release with RESET_PC=16'h0000, deq_ready=1 -> imem_addr 0,1,2,… one per cycle; instr_pc 0,1,2,… from cycle 2 with no bubbles.
- deq_ready=0 for 10 cycles -> count saturates at 4, fetch_req drops to 0, imem_addr holds at 16'h0004. Raising deq_ready -> instr_pc 0..3 then 4 with no loss or duplication.
- redirect_valid with redirect_pc=16'h0040 while full and with inflight=1 -> instr_valid=0 that cycle; next valid instr_pc=16'h0040 at R+3; stale data is never presented.
- fetch_pc=16'hFFFE sequential fetch -> instr_pc FFFE, FFFF, 0000.
- reset asserted while count=3 and inflight=1 -> instr_valid=0 and count=0 asynchronously; after release, fetch restarts at RESET_PC.
- FETCHQ_BYPASS_EN build: empty queue with deq_ready=1 -> instr_valid in N+1 with count staying 0. With deq_ready=0 -> count becomes 1.

Source files
------------

// File: rtl/fetchq_pkg.sv
// Shared types for the instruction prefetch queue: word width and the
// queue entry that pairs an instruction word with the PC it was fetched from.
package fetchq_pkg;

  localparam int WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of fetched entries. The pointers carry an extra wrap bit,
// so full and empty are distinguished without a separate occupancy register.
module fetchq_fifo
  import fetchq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  fq_entry_t wdata,
  input  logic      pop,
  input  logic      flush,
  output fq_entry_t rdata,
  output logic [AW:0] count,
  output logic      empty
);

  localparam logic [AW:0] PTR_ONE = 1;

  fq_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head outputs read as zero until filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: sequential fetch, one-cycle response capture,
// redirect flush. FETCHQ_BYPASS_EN enables the empty-queue response bypass.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  output logic              fetch_req,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              deq_ready,
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] fetch_pc;
  logic              inflight;
  fq_entry_t         resp;
  fq_entry_t         head;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic              bypass;

  // A response in flight always belongs to the address just before fetch_pc.
  assign resp = '{instr: imem_data, pc: fetch_pc - 16'd1};

  assign imem_addr = fetch_pc;
  assign fetch_req = reset && !redirect_valid && ((int'(count) + int'(inflight)) < DEPTH);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = q_empty && inflight && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = !redirect_valid && (!q_empty || bypass);
  assign instr       = bypass ? resp.instr : head.instr;
  assign instr_pc    = bypass ? resp.pc    : head.pc;
  assign push        = inflight && !redirect_valid && !(bypass && deq_ready);
  assign pop         = instr_valid && deq_ready && !bypass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= fetch_req;
      if (fetch_req) fetch_pc <= fetch_pc + 16'd1;
    end
  end

  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (resp),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .count (count),
    .empty (q_empty)
  );

endmodule
